// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents:
//   DATA_W, ADDR_W, XZR_IDX : default data width, address width and zero-register index
//   wb_req_t                : one writeback request (destination address + data)
package regfile_pkg;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int XZR_IDX = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// wb_slot: single-entry holding slot for one writeback requester.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   load              : capture load_addr/load_data and mark the slot full
//   load_addr/_data   : incoming request contents
//   clear             : slot was written to the regfile this cycle (empties unless reloaded)
//   full, addr, data  : registered slot state
module wb_slot #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A same-edge load wins over clear: the granted entry leaves and the new one takes its place.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only observed while full is set, so
  // resetting it would buy nothing but extra reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      addr <= load_addr;
      data <= load_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU (req0) and load (req1) writeback streams onto the
// single regfile write port.
// Ports:
//   clk, reset                    : clock, synchronous active-low reset
//   reqN_valid/ready/addr/data    : per-requester valid/ready handshake (N = 0 ALU, 1 load)
//   we3, wa3, wd3                 : regfile write port, combinational from held state
//   pending                       : one bit per register with an accepted, unwritten write
// Each requester owns one wb_slot. Writes to the zero register are acknowledged and
// dropped. Different addresses arbitrate round-robin; equal addresses go oldest first so
// the later value is the one left in the regfile.
module regfile_wb_arbiter #(
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int XZR_IDX = regfile_pkg::XZR_IDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 we3,
  output logic [ADDR_W-1:0]    wa3,
  output logic [DATA_W-1:0]    wd3,
  output logic [2**ADDR_W-1:0] pending
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              grant0, grant1;
  logic              load0, load1;
  logic              ptr;     // round-robin pointer: 0 selects slot 0
  logic              older1;  // slot 1 holds the earlier handshake (meaningful when both full)
  logic              pick1;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .load_addr (req0_addr),
    .load_data (req0_data),
    .clear     (grant0),
    .full      (full0),
    .addr      (addr0),
    .data      (data0)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .load_addr (req1_addr),
    .load_data (req1_data),
    .clear     (grant1),
    .full      (full1),
    .addr      (addr1),
    .data      (data1)
  );

  // Grant is suppressed while reset is low so a slot about to be discarded never
  // reaches the regfile on the reset edge.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    pick1  = 1'b0;
    if (reset) begin
      if (full0 && full1) begin
        pick1  = (addr0 == addr1) ? older1 : ptr;
        grant0 = !pick1;
        grant1 = pick1;
      end else begin
        grant0 = full0;
        grant1 = full1;
      end
    end
  end

  assign we3 = grant0 | grant1;
  assign wa3 = grant0 ? addr0 : (grant1 ? addr1 : '0);
  assign wd3 = grant0 ? data0 : (grant1 ? data1 : '0);

  // Ready comes from state (and reset) only; a slot being drained this cycle can take a new entry.
  assign req0_ready = !reset || !full0 || grant0;
  assign req1_ready = !reset || !full1 || grant1;

  // Zero-register handshakes complete but never occupy the slot.
  assign load0 = reset && req0_valid && req0_ready && (req0_addr != XZR);
  assign load1 = reset && req1_valid && req1_ready && (req1_addr != XZR);

  // Age flag: a lone new load is younger than whatever survives in the other slot;
  // on a same-edge pair (or a lone load into slot 1) slot 0 counts as older.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr    <= 1'b0;
      older1 <= 1'b0;
    end else begin
      if (grant0) begin
        ptr <= 1'b1;
      end else if (grant1) begin
        ptr <= 1'b0;
      end
      if (load0 && !load1) begin
        older1 <= full1 && !grant1;
      end else if (load1) begin
        older1 <= 1'b0;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (full0) pending[addr0] = 1'b1;
    if (full1) pending[addr1] = 1'b1;
    pending[XZR_IDX] = 1'b0;
    if (!reset) pending = '0;
  end

endmodule
